// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_t       : controller state encoding (IDLE / RUN / DONE)
//   DEFAULT_WIDTH : default operand width
package adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder built from two half-adder stages and an OR gate.
// Ports:
//   a, b  : input addend bits
//   cin   : input carry
//   sum   : a ^ b ^ cin
//   cout  : carry out
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic ha1_sum;
    logic ha1_carry;
    logic ha2_carry;

    assign ha1_sum   = a ^ b;
    assign ha1_carry = a & b;

    assign sum       = ha1_sum ^ cin;
    assign ha2_carry = ha1_sum & cin;

    // At most one of the two half-adder carries can be set.
    assign cout      = ha1_carry | ha2_carry;

endmodule

// File: rtl/bit_serial_adder.sv
// Multi-cycle adder: a + b + c_in computed one bit per clock, LSB first,
// through a single full_adder_cell and a carry flip-flop.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : latch a, b, c_in and begin an addition (honoured in IDLE/DONE)
//   a, b   : WIDTH-bit operands
//   c_in   : carry-in
//   busy   : high while the addition runs (WIDTH cycles)
//   done   : one-cycle pulse when sum/c_out take a new result
//   sum    : result mod 2^WIDTH, held until the next completion
//   c_out  : carry out of bit WIDTH-1, held with sum
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | one bit added per edge, cnt tracks bit position
// DONE   | result just published; start here chains back-to-back
module bit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             bit_sum;
    logic             bit_cout;

    full_adder_cell u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (bit_sum),
        .cout (bit_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= c_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    s_sh  <= {bit_sum, s_sh[WIDTH-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= bit_cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        // Final bit goes straight to the output; s_sh is not yet updated.
                        sum   <= {bit_sum, s_sh[WIDTH-1:1]};
                        c_out <= bit_cout;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
module tb_bit_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       c8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       c2 = 1'b0;
    logic       busy2, done2, cout2;
    logic [1:0] sum2;

    int checks = 0;
    int errors = 0;

    logic [7:0] last_sum  = '0;
    logic       last_cout = 1'b0;

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .c_in(c8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8)
    );

    bit_serial_adder #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .c_in(c2),
        .busy(busy2), .done(done2), .sum(sum2), .c_out(cout2)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] es;
        logic       ec;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Called at #1 after an edge with the DUT in IDLE or DONE.
    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic ci);
        a8 = a; b8 = b; c8 = ci; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
    endtask

    task automatic finish8(input int inj, output int lat, output int bn, output int hold_bad);
        lat = -1;
        bn = busy8 ? 1 : 0;
        hold_bad = 0;
        if (sum8 !== last_sum || cout8 !== last_cout) hold_bad++;
        for (int j = 1; j <= 40; j++) begin
            @(posedge clk); #1;
            start8 = 1'b0;
            if (done8) begin
                lat = j;
                break;
            end
            if (busy8) bn++;
            if (sum8 !== last_sum || cout8 !== last_cout) hold_bad++;
            if (j == inj) begin
                start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; c8 = 1'b0;
            end
        end
    endtask

    task automatic op8(input string nm, input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic [7:0] es, input logic ec, input int inj);
        int lat, bn, hb;
        launch8(a, b, ci);
        finish8(inj, lat, bn, hb);
        chk({nm, ".latency"}, 32'(lat), 32'd8);
        chk({nm, ".busy_cycles"}, 32'(bn), 32'd8);
        chk({nm, ".held_during_run"}, 32'(hb), 32'd0);
        chk({nm, ".busy_at_done"}, {31'd0, busy8}, 32'd0);
        chk({nm, ".sum"}, {24'd0, sum8}, {24'd0, es});
        chk({nm, ".c_out"}, {31'd0, cout8}, {31'd0, ec});
        last_sum  = es;
        last_cout = ec;
    endtask

    task automatic idle_check(input string nm);
        @(posedge clk); #1;
        chk({nm, ".done_drop"}, {31'd0, done8}, 32'd0);
        chk({nm, ".idle_busy"}, {31'd0, busy8}, 32'd0);
    endtask

    initial begin
        logic [8:0] ref9;
        logic [2:0] ref3;
        logic [7:0] ra, rb;
        logic       rc;
        int         lat;
        int         seen_done;

        tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        tbl[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

        // Reset without any clock edge.
        #1 rst_n = 1'b0;
        #2;
        chk("rst.busy", {31'd0, busy8}, 32'd0);
        chk("rst.done", {31'd0, done8}, 32'd0);
        chk("rst.sum", {24'd0, sum8}, 32'd0);
        chk("rst.c_out", {31'd0, cout8}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            op8($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].es, tbl[i].ec, 0);
            idle_check($sformatf("tbl%0d", i));
        end

        // start during RUN is ignored.
        op8("ignore", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 3);
        idle_check("ignore");

        // Back-to-back: launch directly from the DONE cycle.
        op8("b2b_first", 8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 0);
        op8("b2b_second", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0);
        idle_check("b2b");

        // Abort: reset mid-RUN.
        op8("pre_abort", 8'h5C, 8'h21, 1'b1, 8'h7E, 1'b0, 0);
        launch8(8'h0F, 8'h0F, 1'b0);
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("abort.busy", {31'd0, busy8}, 32'd0);
        chk("abort.done", {31'd0, done8}, 32'd0);
        chk("abort.sum", {24'd0, sum8}, 32'd0);
        chk("abort.c_out", {31'd0, cout8}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen_done = 0;
        for (int j = 0; j < 12; j++) begin
            @(posedge clk); #1;
            if (done8) seen_done++;
        end
        chk("abort.no_done", 32'(seen_done), 32'd0);
        chk("abort.sum_after", {24'd0, sum8}, 32'd0);
        last_sum = '0; last_cout = 1'b0;
        op8("post_abort", 8'h0F, 8'h0F, 1'b0, 8'h1E, 1'b0, 0);
        idle_check("post_abort");

        // Random operands against plain arithmetic, some chained back-to-back.
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            ref9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            op8($sformatf("rnd%0d", i), ra, rb, rc, ref9[7:0], ref9[8], 0);
            if ($urandom_range(0, 1) == 0) idle_check($sformatf("rnd%0d", i));
        end

        // Exhaustive WIDTH=2.
        for (int ia = 0; ia < 4; ia++) begin
            for (int ib = 0; ib < 4; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a2 = 2'(ia); b2 = 2'(ib); c2 = 1'(ic); start2 = 1'b1;
                    @(posedge clk); #1;
                    start2 = 1'b0;
                    lat = -1;
                    for (int j = 1; j <= 10; j++) begin
                        @(posedge clk); #1;
                        if (done2) begin
                            lat = j;
                            break;
                        end
                    end
                    ref3 = 3'(ia + ib + ic);
                    chk($sformatf("w2_%0d_%0d_%0d.latency", ia, ib, ic), 32'(lat), 32'd2);
                    chk($sformatf("w2_%0d_%0d_%0d.result", ia, ib, ic),
                        {29'd0, cout2, sum2}, {29'd0, ref3});
                    @(posedge clk); #1;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
